// File: rtl/serial_pkg.sv
// Shared types for the serial comparator transmitter and its benches.
package serial_pkg;

    typedef enum logic [0:0] {
        st_idle  = 1'b0,
        st_shift = 1'b1
    } state_t;

    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
    } cmp_result_t;

endpackage

// File: rtl/serial_shift_lane.sv
// One operand lane: parallel load, then presents one bit per shift in the selected order.
module serial_shift_lane #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // The last bit is never shifted out, so dout holds it after the frame ends.
    assign dout = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_pair_transmitter.sv
// Serialises an operand pair one bit pair per cycle with first/last framing and a reference compare.
module serial_pair_transmitter
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_first,
    output logic             ser_last,
    output logic             ref_less,
    output logic             ref_eq,
    output logic             ref_greater
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        first_q, first_d;
    cmp_result_t ref_q, ref_d;

    logic accept;
    logic advance;
    logic last_bit;
    logic lane_shift;

    // Handshakes: a transfer happens on a posedge where valid & ready are both high.
    always_comb begin
        ser_valid  = (state_q == st_shift);
        last_bit   = ser_valid & (cnt_q == '0);
        ser_last   = last_bit;
        ser_first  = ser_valid & first_q;
        advance    = ser_valid & ser_ready;
        up_ready   = rst & ((state_q == st_idle) | (advance & last_bit));
        accept     = up_valid & up_ready;
        lane_shift = advance & ~last_bit;

        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        ref_d   = ref_q;

        if (accept) begin
            state_d       = st_shift;
            cnt_d         = CNT_LOAD;
            first_d       = 1'b1;
            ref_d.less    = (up_a < up_b);
            ref_d.eq      = (up_a == up_b);
            ref_d.greater = (up_a > up_b);
        end else if (advance) begin
            first_d = 1'b0;
            if (last_bit) begin
                state_d = st_idle;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= st_idle;
            cnt_q   <= '0;
            first_q <= 1'b0;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            ref_q   <= ref_d;
        end
    end

    assign ref_less    = ref_q.less;
    assign ref_eq      = ref_q.eq;
    assign ref_greater = ref_q.greater;

    serial_shift_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (lane_shift),
        .din   (up_a),
        .dout  (ser_a)
    );

    serial_shift_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (lane_shift),
        .din   (up_b),
        .dout  (ser_b)
    );

endmodule

// File: tb/tb_serial_pair_transmitter.sv
// Bench for serial_pair_transmitter: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_serial_pair_transmitter;

    localparam int W = 8;

    typedef logic [1:0][6:0] beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         up_valid;
    logic [W-1:0] up_a;
    logic [W-1:0] up_b;
    logic         ser_ready;

    logic up_ready_m, ser_valid_m, ser_a_m, ser_b_m, ser_first_m, ser_last_m;
    logic ref_less_m, ref_eq_m, ref_greater_m;
    logic up_ready_l, ser_valid_l, ser_a_l, ser_b_l, ser_first_l, ser_last_l;
    logic ref_less_l, ref_eq_l, ref_greater_l;

    serial_pair_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready_m),
        .up_a(up_a), .up_b(up_b), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
        .ser_a(ser_a_m), .ser_b(ser_b_m), .ser_first(ser_first_m), .ser_last(ser_last_m),
        .ref_less(ref_less_m), .ref_eq(ref_eq_m), .ref_greater(ref_greater_m)
    );

    serial_pair_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready_l),
        .up_a(up_a), .up_b(up_b), .ser_valid(ser_valid_l), .ser_ready(ser_ready),
        .ser_a(ser_a_l), .ser_b(ser_b_l), .ser_first(ser_first_l), .ser_last(ser_last_l),
        .ref_less(ref_less_l), .ref_eq(ref_eq_l), .ref_greater(ref_greater_l)
    );

    // Observed word per instance: {ser_a, ser_b, ser_first, ser_last, less, eq, greater}
    logic [1:0][6:0] obs;
    logic [1:0]      vld;
    logic [1:0]      urdy;
    assign obs[0] = {ser_a_m, ser_b_m, ser_first_m, ser_last_m, ref_less_m, ref_eq_m, ref_greater_m};
    assign obs[1] = {ser_a_l, ser_b_l, ser_first_l, ser_last_l, ref_less_l, ref_eq_l, ref_greater_l};
    assign vld    = {ser_valid_l, ser_valid_m};
    assign urdy   = {up_ready_l, up_ready_m};

    beat_t        exp_q[$];
    logic [W-1:0] frm_a[16];
    logic [W-1:0] frm_b[16];
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic test_reset();
        rst       = 1'b0;
        up_valid  = 1'b1;
        up_a      = W'($urandom);
        up_b      = W'($urandom);
        ser_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({vld[d], urdy[d], obs[d]} !== 9'd0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got valid=%b up_ready=%b word=%b, want all 0",
                         d, vld[d], urdy[d], obs[d]);
            end
        end
        rst      = 1'b1;
        up_valid = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (urdy[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_release_ready dut%0d: got up_ready=%b, want 1", d, urdy[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (vld[d] !== 1'b0 || urdy[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL idle_after_reset dut%0d: got valid=%b up_ready=%b, want valid=0 up_ready=1",
                         d, vld[d], urdy[d]);
            end
        end
    endtask

    // Sends frm_a/frm_b[0..nf-1] with up_valid held high and checks every beat of both instances.
    task automatic run_stream(input string name, input int nf, input int stall_at,
                              input int stall_len, input bit rnd_ready);
        beat_t      e;
        beat_t      last_e;
        beat_t      want;
        logic [2:0] r;
        int total;
        int consumed = 0;
        int sent     = 0;
        int stalls   = 0;
        int vcycles  = 0;
        int iter     = 0;
        bit started  = 1'b0;
        bit acc      = 1'b0;

        exp_q.delete();
        last_e = '0;
        for (int f = 0; f < nf; f++) begin
            r = {frm_a[f] < frm_b[f], frm_a[f] == frm_b[f], frm_a[f] > frm_b[f]};
            for (int i = 0; i < W; i++) begin
                e[0] = {frm_a[f][W-1-i], frm_b[f][W-1-i], i == 0, i == W - 1, r};
                e[1] = {frm_a[f][i], frm_b[f][i], i == 0, i == W - 1, r};
                exp_q.push_back(e);
            end
        end
        total = exp_q.size();

        @(negedge clk);
        up_valid = 1'b1;
        up_a     = frm_a[0];
        up_b     = frm_b[0];
        while (consumed < total && iter < 400) begin
            iter++;
            if (started) begin
                vcycles++;
                for (int d = 0; d < 2; d++) begin
                    n_cmp++;
                    if (vld[d] !== 1'b1 || obs[d] !== exp_q[0][d]) begin
                        n_bad++;
                        $display("FAIL %s beat%0d dut%0d: got valid=%b word=%b, want valid=1 word=%b",
                                 name, consumed, d, vld[d], obs[d], exp_q[0][d]);
                    end
                end
            end
            if (rnd_ready) begin
                ser_ready = ($urandom_range(0, 3) != 0);
            end else if (consumed == stall_at && stalls < stall_len) begin
                ser_ready = 1'b0;
                stalls++;
            end else begin
                ser_ready = 1'b1;
            end
            #1;
            acc = up_valid & up_ready_m;
            if (started && ser_valid_m && ser_ready) begin
                last_e = exp_q.pop_front();
                consumed++;
            end
            @(negedge clk);
            if (acc) begin
                started = 1'b1;
                sent++;
                if (sent < nf) begin
                    up_a = frm_a[sent];
                    up_b = frm_b[sent];
                end else begin
                    up_valid = 1'b0;
                    up_a     = W'($urandom);
                    up_b     = W'($urandom);
                end
            end
        end

        if (consumed < total) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: consumed %0d of %0d beats", name, consumed, total);
        end else begin
            ser_ready = 1'(($urandom_range(0, 1)));
            for (int d = 0; d < 2; d++) begin
                want[d] = {last_e[d][6:5], 2'b00, last_e[d][2:0]};
                n_cmp++;
                if (vld[d] !== 1'b0 || obs[d] !== want[d]) begin
                    n_bad++;
                    $display("FAIL %s frame_end_idle dut%0d: got valid=%b word=%b, want valid=0 word=%b",
                             name, d, vld[d], obs[d], want[d]);
                end
            end
            if (!rnd_ready) begin
                n_cmp++;
                if (vcycles != total + stall_len) begin
                    n_bad++;
                    $display("FAIL %s valid_cycles: got %0d, want %0d", name, vcycles, total + stall_len);
                end
            end
        end
        up_valid  = 1'b0;
        ser_ready = 1'b0;
    endtask

    task automatic test_single_frame();
        frm_a[0] = 8'hA5;
        frm_b[0] = 8'hA3;
        run_stream("single", 1, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        frm_a[0] = 8'hA5;
        frm_b[0] = 8'hA3;
        run_stream("stall", 1, 3, 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        frm_a[0] = 8'h10;
        frm_b[0] = 8'h10;
        frm_a[1] = 8'h0F;
        frm_b[1] = 8'h80;
        run_stream("back_to_back", 2, -1, 0, 1'b0);
    endtask

    task automatic test_lsb_order();
        frm_a[0] = 8'h01;
        frm_b[0] = 8'h80;
        run_stream("lsb_order", 1, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            frm_a[f] = W'($urandom);
            frm_b[f] = (f == 2) ? frm_a[f] : W'($urandom);
        end
        run_stream("random", 6, -1, 0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        up_valid  = 1'b1;
        up_a      = 8'hA5;
        up_b      = 8'hA3;
        ser_ready = 1'b1;
        @(negedge clk);
        up_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({ser_valid_m, ser_a_m, ser_b_m, ser_first_m} !== 4'b1000) begin
            n_bad++;
            $display("FAIL mid_frame_bit4: got valid=%b a=%b b=%b first=%b, want 1 0 0 0",
                     ser_valid_m, ser_a_m, ser_b_m, ser_first_m);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({vld[d], urdy[d], obs[d]} !== 9'd0) begin
                n_bad++;
                $display("FAIL mid_frame_reset dut%0d: got valid=%b up_ready=%b word=%b, want all 0",
                         d, vld[d], urdy[d], obs[d]);
            end
        end
        rst      = 1'b1;
        frm_a[0] = 8'hFF;
        frm_b[0] = 8'h00;
        run_stream("after_reset", 1, -1, 0, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        up_valid  = 1'b0;
        up_a      = '0;
        up_b      = '0;
        ser_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_lsb_order();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
